// File: rtl/core_axi_arb.sv
// Unified-memory AXI-lite arbiter for the fetch and data ports.
// One transaction in flight; I vs D round-robin, D writes beat D reads.
module core_axi_arb #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    NRST,

  input  logic [AXI_AWIDTH-1:0]   IMEM_AXI_ARADDR,
  input  logic                    IMEM_AXI_ARVALID,
  output logic                    IMEM_AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   IMEM_AXI_RDATA,
  output logic [1:0]              IMEM_AXI_RRESP,
  output logic                    IMEM_AXI_RVALID,
  input  logic                    IMEM_AXI_RREADY,

  input  logic [AXI_AWIDTH-1:0]   HOST_AXI_AWADDR,
  input  logic                    HOST_AXI_AWVALID,
  output logic                    HOST_AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   HOST_AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] HOST_AXI_WSTRB,
  input  logic                    HOST_AXI_WVALID,
  output logic                    HOST_AXI_WREADY,
  output logic [1:0]              HOST_AXI_BRESP,
  output logic                    HOST_AXI_BVALID,
  input  logic                    HOST_AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   HOST_AXI_ARADDR,
  input  logic                    HOST_AXI_ARVALID,
  output logic                    HOST_AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   HOST_AXI_RDATA,
  output logic [1:0]              HOST_AXI_RRESP,
  output logic                    HOST_AXI_RVALID,
  input  logic                    HOST_AXI_RREADY,

  output logic [AXI_AWIDTH-1:0]   MEM_AXI_AWADDR,
  output logic                    MEM_AXI_AWVALID,
  input  logic                    MEM_AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   MEM_AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] MEM_AXI_WSTRB,
  output logic                    MEM_AXI_WVALID,
  input  logic                    MEM_AXI_WREADY,
  input  logic [1:0]              MEM_AXI_BRESP,
  input  logic                    MEM_AXI_BVALID,
  output logic                    MEM_AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   MEM_AXI_ARADDR,
  output logic                    MEM_AXI_ARVALID,
  input  logic                    MEM_AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   MEM_AXI_RDATA,
  input  logic [1:0]              MEM_AXI_RRESP,
  input  logic                    MEM_AXI_RVALID,
  output logic                    MEM_AXI_RREADY
);

  typedef enum logic [1:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   ar_done, ar_done_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;

  logic   d_req, grant_i;
  logic   ar_hs, aw_hs, w_hs;
  logic   r_hs, b_hs, wr_ok;

  assign d_req   = HOST_AXI_AWVALID | HOST_AXI_ARVALID;
  assign grant_i = IMEM_AXI_ARVALID &
                   (~d_req | (last_grant == GNT_D));

  assign ar_hs = MEM_AXI_ARVALID & MEM_AXI_ARREADY;
  assign aw_hs = MEM_AXI_AWVALID & MEM_AXI_AWREADY;
  assign w_hs  = MEM_AXI_WVALID & MEM_AXI_WREADY;
  assign r_hs  = MEM_AXI_RVALID & MEM_AXI_RREADY;
  assign b_hs  = MEM_AXI_BVALID & MEM_AXI_BREADY;

  // B may only be taken once both AW and W are in, this cycle or earlier
  assign wr_ok = (aw_done | aw_hs) & (w_done | w_hs);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      ar_done    <= ar_done_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    ar_done_nxt    = ar_done;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;
    unique case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt      = I_RD;
          last_grant_nxt = GNT_I;
        end else if (HOST_AXI_AWVALID) begin
          state_nxt      = D_WR;
          last_grant_nxt = GNT_D;
        end else if (HOST_AXI_ARVALID) begin
          state_nxt      = D_RD;
          last_grant_nxt = GNT_D;
        end
      end
      I_RD, D_RD: begin
        if (ar_hs) ar_done_nxt = 1'b1;
        if (r_hs) begin
          state_nxt   = IDLE;
          ar_done_nxt = 1'b0;
        end
      end
      D_WR: begin
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if (b_hs) begin
          state_nxt   = IDLE;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    IMEM_AXI_ARREADY = 1'b0;
    IMEM_AXI_RDATA   = '0;
    IMEM_AXI_RRESP   = 2'b00;
    IMEM_AXI_RVALID  = 1'b0;
    HOST_AXI_AWREADY = 1'b0;
    HOST_AXI_WREADY  = 1'b0;
    HOST_AXI_BRESP   = 2'b00;
    HOST_AXI_BVALID  = 1'b0;
    HOST_AXI_ARREADY = 1'b0;
    HOST_AXI_RDATA   = '0;
    HOST_AXI_RRESP   = 2'b00;
    HOST_AXI_RVALID  = 1'b0;
    MEM_AXI_AWADDR   = '0;
    MEM_AXI_AWVALID  = 1'b0;
    MEM_AXI_WDATA    = '0;
    MEM_AXI_WSTRB    = '0;
    MEM_AXI_WVALID   = 1'b0;
    MEM_AXI_BREADY   = 1'b0;
    MEM_AXI_ARADDR   = '0;
    MEM_AXI_ARVALID  = 1'b0;
    MEM_AXI_RREADY   = 1'b0;
    unique case (state)
      IDLE: ;
      I_RD: begin
        MEM_AXI_ARADDR   = IMEM_AXI_ARADDR;
        MEM_AXI_ARVALID  = IMEM_AXI_ARVALID & ~ar_done;
        IMEM_AXI_ARREADY = MEM_AXI_ARREADY & ~ar_done;
        IMEM_AXI_RDATA   = MEM_AXI_RDATA;
        IMEM_AXI_RRESP   = MEM_AXI_RRESP;
        IMEM_AXI_RVALID  = MEM_AXI_RVALID;
        MEM_AXI_RREADY   = IMEM_AXI_RREADY;
      end
      D_RD: begin
        MEM_AXI_ARADDR   = HOST_AXI_ARADDR;
        MEM_AXI_ARVALID  = HOST_AXI_ARVALID & ~ar_done;
        HOST_AXI_ARREADY = MEM_AXI_ARREADY & ~ar_done;
        HOST_AXI_RDATA   = MEM_AXI_RDATA;
        HOST_AXI_RRESP   = MEM_AXI_RRESP;
        HOST_AXI_RVALID  = MEM_AXI_RVALID;
        MEM_AXI_RREADY   = HOST_AXI_RREADY;
      end
      D_WR: begin
        MEM_AXI_AWADDR   = HOST_AXI_AWADDR;
        MEM_AXI_AWVALID  = HOST_AXI_AWVALID & ~aw_done;
        HOST_AXI_AWREADY = MEM_AXI_AWREADY & ~aw_done;
        MEM_AXI_WDATA    = HOST_AXI_WDATA;
        MEM_AXI_WSTRB    = HOST_AXI_WSTRB;
        MEM_AXI_WVALID   = HOST_AXI_WVALID & ~w_done;
        HOST_AXI_WREADY  = MEM_AXI_WREADY & ~w_done;
        HOST_AXI_BRESP   = MEM_AXI_BRESP;
        HOST_AXI_BVALID  = MEM_AXI_BVALID & wr_ok;
        MEM_AXI_BREADY   = HOST_AXI_BREADY & wr_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_axi_arb.sv
// Directed bench for core_axi_arb: arbitration table plus
// hand-written fetch, write-ordering, error and reset sequences.
module tb_core_axi_arb;

  localparam logic [31:0] IA = 32'h0000_0010;
  localparam logic [31:0] DA = 32'h2000_0000;
  localparam logic [31:0] WA = 32'h8000_0004;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  logic        CLK, NRST;
  logic [31:0] i_araddr;
  logic        i_arvalid, i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid, i_rready;
  logic [31:0] h_awaddr;
  logic        h_awvalid, h_awready;
  logic [31:0] h_wdata;
  logic [3:0]  h_wstrb;
  logic        h_wvalid, h_wready;
  logic [1:0]  h_bresp;
  logic        h_bvalid, h_bready;
  logic [31:0] h_araddr;
  logic        h_arvalid, h_arready;
  logic [31:0] h_rdata;
  logic [1:0]  h_rresp;
  logic        h_rvalid, h_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rready;

  core_axi_arb #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .CLK(CLK), .NRST(NRST),
    .IMEM_AXI_ARADDR(i_araddr), .IMEM_AXI_ARVALID(i_arvalid),
    .IMEM_AXI_ARREADY(i_arready), .IMEM_AXI_RDATA(i_rdata),
    .IMEM_AXI_RRESP(i_rresp), .IMEM_AXI_RVALID(i_rvalid),
    .IMEM_AXI_RREADY(i_rready),
    .HOST_AXI_AWADDR(h_awaddr), .HOST_AXI_AWVALID(h_awvalid),
    .HOST_AXI_AWREADY(h_awready), .HOST_AXI_WDATA(h_wdata),
    .HOST_AXI_WSTRB(h_wstrb), .HOST_AXI_WVALID(h_wvalid),
    .HOST_AXI_WREADY(h_wready), .HOST_AXI_BRESP(h_bresp),
    .HOST_AXI_BVALID(h_bvalid), .HOST_AXI_BREADY(h_bready),
    .HOST_AXI_ARADDR(h_araddr), .HOST_AXI_ARVALID(h_arvalid),
    .HOST_AXI_ARREADY(h_arready), .HOST_AXI_RDATA(h_rdata),
    .HOST_AXI_RRESP(h_rresp), .HOST_AXI_RVALID(h_rvalid),
    .HOST_AXI_RREADY(h_rready),
    .MEM_AXI_AWADDR(m_awaddr), .MEM_AXI_AWVALID(m_awvalid),
    .MEM_AXI_AWREADY(m_awready), .MEM_AXI_WDATA(m_wdata),
    .MEM_AXI_WSTRB(m_wstrb), .MEM_AXI_WVALID(m_wvalid),
    .MEM_AXI_WREADY(m_wready), .MEM_AXI_BRESP(m_bresp),
    .MEM_AXI_BVALID(m_bvalid), .MEM_AXI_BREADY(m_bready),
    .MEM_AXI_ARADDR(m_araddr), .MEM_AXI_ARVALID(m_arvalid),
    .MEM_AXI_ARREADY(m_arready), .MEM_AXI_RDATA(m_rdata),
    .MEM_AXI_RRESP(m_rresp), .MEM_AXI_RVALID(m_rvalid),
    .MEM_AXI_RREADY(m_rready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;

  always @(posedge CLK) begin
    if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
    if (m_wvalid && m_wready)   w_cnt  <= w_cnt + 1;
  end

  typedef struct {
    logic i, dr, dw, wv;
    int   exp;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // 0 none, 1 fetch read, 2 data read, 3 data write
  function automatic int gcode();
    if (m_awvalid) return 3;
    if (m_arvalid && m_araddr == IA) return 1;
    if (m_arvalid && m_araddr == DA) return 2;
    return 0;
  endfunction

  function automatic logic [9:0] act_bits();
    return {m_awvalid, m_wvalid, m_arvalid, m_bready,
            m_rready, h_bvalid, h_rvalid, i_rvalid,
            h_awready, h_wready};
  endfunction

  task automatic drop_all();
    i_arvalid = 0; h_arvalid = 0;
    h_awvalid = 0; h_wvalid  = 0;
  endtask

  task automatic do_reset();
    NRST = 0;
    drop_all();
    step();
    step();
    NRST = 1;
  endtask

  task automatic finish_txn(input int g);
    if (g == 1 || g == 2) begin
      m_arready = 1;
      step();
      m_arready = 0;
      if (g == 1) i_arvalid = 0;
      else        h_arvalid = 0;
      m_rdata  = 32'h1234_5678;
      m_rresp  = 2'b00;
      m_rvalid = 1;
      step();
      m_rvalid = 0;
    end else if (g == 3) begin
      m_awready = 1;
      m_wready  = 1;
      step();
      m_awready = 0;
      m_wready  = 0;
      h_awvalid = 0;
      h_wvalid  = 0;
      m_bvalid  = 1;
      step();
      m_bvalid  = 0;
    end
  endtask

  task automatic write_sweep(input int ord);
    int aw0, w0;
    h_awaddr  = WA; h_wdata = WD; h_wstrb = 4'hF;
    h_awvalid = 1;  h_wvalid = 1;
    step();
    aw0 = aw_cnt; w0 = w_cnt;
    chk($sformatf("wr%0d_awaddr", ord), m_awaddr, WA);
    if (ord == 2) begin
      m_awready = 1; m_wready = 1;
      #1;
      chk($sformatf("wr%0d_bready_same", ord), m_bready, 1);
      step();
      m_awready = 0; m_wready = 0;
    end else begin
      if (ord == 0) m_awready = 1;
      else          m_wready  = 1;
      #1;
      chk($sformatf("wr%0d_bready_half", ord), m_bready, 0);
      step();
      m_awready = 0; m_wready = 0;
      #1;
      chk($sformatf("wr%0d_done_valid", ord),
          ord == 0 ? m_awvalid : m_wvalid, 0);
      chk($sformatf("wr%0d_bready_wait", ord), m_bready, 0);
      if (ord == 0) m_wready  = 1;
      else          m_awready = 1;
      #1;
      chk($sformatf("wr%0d_wdata", ord), {m_wstrb, m_wdata},
          {4'hF, WD});
      chk($sformatf("wr%0d_bready_last", ord), m_bready, 1);
      step();
      m_awready = 0; m_wready = 0;
    end
    m_bvalid = 1; m_bresp = 2'b00;
    #1;
    chk($sformatf("wr%0d_hbvalid", ord), h_bvalid, 1);
    step();
    m_bvalid = 0;
    drop_all();
    #1;
    chk($sformatf("wr%0d_aw_cnt", ord), aw_cnt - aw0, 1);
    chk($sformatf("wr%0d_w_cnt", ord), w_cnt - w0, 1);
    chk($sformatf("wr%0d_idle", ord), act_bits(), 0);
  endtask

  initial begin
    NRST = 0;
    i_araddr = IA; i_arvalid = 0; i_rready = 1;
    h_awaddr = WA; h_awvalid = 0; h_wdata = WD;
    h_wstrb = 4'hF; h_wvalid = 0; h_bready = 1;
    h_araddr = DA; h_arvalid = 0; h_rready = 1;
    m_awready = 0; m_wready = 0; m_bresp = 0;
    m_bvalid = 0; m_arready = 0; m_rdata = 0;
    m_rresp = 0; m_rvalid = 0;

    tbl[0]  = '{0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 2};
    tbl[5]  = '{1, 1, 0, 0, 1};
    tbl[6]  = '{1, 0, 1, 1, 3};
    tbl[7]  = '{0, 1, 1, 1, 3};
    tbl[8]  = '{1, 1, 1, 1, 1};
    tbl[9]  = '{1, 1, 1, 1, 3};
    tbl[10] = '{0, 1, 0, 0, 2};
    tbl[11] = '{1, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 1, 1, 3};

    #3;
    chk("reset_outputs", act_bits(), 0);
    step();
    NRST = 1;

    // single fetch, memory ARREADY two cycles late
    i_arvalid = 1;
    #1;
    chk("fetch_idle", m_arvalid, 0);
    step();
    chk("fetch_grant", gcode(), 1);
    chk("fetch_noready", i_arready, 0);
    step();
    step();
    m_arready = 1;
    #1;
    chk("fetch_arready", i_arready, 1);
    step();
    m_arready = 0;
    #1;
    chk("fetch_ar_done", m_arvalid, 0);
    i_arvalid = 0;
    m_rdata = 32'h0000_0013; m_rresp = 2'b00; m_rvalid = 1;
    #1;
    chk("fetch_r", {i_rvalid, i_rresp, i_rdata},
        {1'b1, 2'b00, 32'h13});
    chk("fetch_host_quiet", {h_rvalid, h_arready}, 0);
    step();
    m_rvalid = 0;
    i_arvalid = 1;
    #1;
    chk("fetch_back_idle", {m_arvalid, m_rready}, 0);
    step();
    chk("fetch_regrant", gcode(), 1);
    finish_txn(1);
    drop_all();

    // tie right after reset: I first, then D
    do_reset();
    i_arvalid = 1; h_arvalid = 1;
    step();
    chk("tie_first_i", gcode(), 1);
    m_arready = 1;
    #1;
    chk("tie_no_host_ready", {h_arready, i_arready}, 2'b01);
    step();
    m_arready = 0; i_arvalid = 0;
    m_rvalid = 1;
    #1;
    chk("tie_host_no_rvalid", h_rvalid, 0);
    step();
    m_rvalid = 0;
    step();
    chk("tie_then_d", gcode(), 2);
    finish_txn(2);
    drop_all();

    // arbitration table from a fresh reset
    do_reset();
    for (int k = 0; k < 13; k++) begin
      i_arvalid = tbl[k].i;
      h_arvalid = tbl[k].dr;
      h_awvalid = tbl[k].dw;
      h_wvalid  = tbl[k].wv;
      #1;
      chk($sformatf("tbl%0d_idle", k), act_bits(), 0);
      step();
      chk($sformatf("tbl%0d_grant", k), gcode(), tbl[k].exp);
      finish_txn(gcode());
      drop_all();
    end

    // write ordering sweep
    for (int o = 0; o < 3; o++) write_sweep(o);

    // write and read together: write, then read, D kept as last
    h_awvalid = 1; h_wvalid = 1; h_arvalid = 1;
    step();
    chk("wr_rd_write_first", gcode(), 3);
    finish_txn(3);
    step();
    chk("wr_rd_read_next", gcode(), 2);
    finish_txn(2);
    drop_all();
    i_arvalid = 1; h_arvalid = 1;
    step();
    chk("wr_rd_then_tie_i", gcode(), 1);
    finish_txn(1);
    drop_all();

    // error response pass-through
    h_arvalid = 1;
    step();
    chk("err_grant", gcode(), 2);
    m_arready = 1;
    step();
    m_arready = 0; h_arvalid = 0;
    m_rresp = 2'b10; m_rdata = 32'hBAD0_0001; m_rvalid = 1;
    #1;
    chk("err_rresp", {h_rvalid, h_rresp, h_rdata},
        {1'b1, 2'b10, 32'hBAD0_0001});
    chk("err_imem_quiet", {i_rvalid, i_rresp, i_rdata}, 0);
    step();
    m_rvalid = 0; m_rresp = 2'b00;
    #1;
    chk("err_idle", act_bits(), 0);

    // reset in the middle of a write, after AW
    h_awvalid = 1; h_wvalid = 1;
    step();
    m_awready = 1;
    step();
    m_awready = 0;
    #1;
    chk("rst_pre_state", {m_awvalid, m_wvalid}, 2'b01);
    #1;
    NRST = 0;
    #1;
    chk("rst_all_zero", act_bits(), 0);
    step();
    NRST = 1;
    step();
    chk("rst_fresh_aw", {m_awvalid, m_awaddr}, {1'b1, WA});
    finish_txn(3);
    drop_all();
    #1;
    chk("rst_end_idle", act_bits(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
